// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
//
// Multi-cycle WIDTH-bit subtractor computing a - b LSB-first, one bit per clock,
// using a one-bit full-subtractor cell and a borrow flop. Operands enter through a
// valid/ready port; the result leaves through a valid/ready port.
//
// Optional feature macro: BIT_SERIAL_ADD_MODE_EN
//   When defined, adds input 'sub' (captured with the operands): sub=1 subtracts,
//   sub=0 adds (borrow_out then reports the final carry). Undefined: subtract only.
//
// Ports:
//   clk         rising-edge clock
//   rstn        synchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    block can accept operands (IDLE)
//   a, b        minuend / subtrahend, WIDTH bits
//   sub         (macro only) 1 = subtract, 0 = add
//   out_valid   result valid (DONE)
//   out_ready   consumer accepts result
//   diff        a - b modulo 2^WIDTH (a + b in add mode)
//   borrow_out  final borrow (final carry in add mode)
//   ovf         signed overflow
//   busy        high while shifting
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BIT_SERIAL_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              br_q, br_d;
    logic              borrow_q, borrow_d;
    logic              ovf_q, ovf_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
`ifdef BIT_SERIAL_ADD_MODE_EN
    logic              sub_q, sub_d;
`endif

    // One-bit cell outputs for the current LSBs.
    logic a0, b0, d_bit, br_sub, br_n, ovf_n;
`ifdef BIT_SERIAL_ADD_MODE_EN
    logic br_add;
`endif

    always_comb begin
        a0     = a_sh_q[0];
        b0     = b_sh_q[0];
        // Sum and difference bits are the same XOR; only the borrow/carry differs.
        d_bit  = a0 ^ b0 ^ br_q;
        br_sub = (~a0 & b0) | (~(a0 ^ b0) & br_q);
`ifdef BIT_SERIAL_ADD_MODE_EN
        br_add = (a0 & b0) | (br_q & (a0 ^ b0));
        br_n   = sub_q ? br_sub : br_add;
        // d_bit is the result MSB on the final shift.
        ovf_n  = sub_q ? ((a_msb_q != b_msb_q) && (d_bit != a_msb_q))
                       : ((a_msb_q == b_msb_q) && (d_bit != a_msb_q));
`else
        br_n   = br_sub;
        ovf_n  = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
`ifdef BIT_SERIAL_ADD_MODE_EN
        sub_d    = sub_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`ifdef BIT_SERIAL_ADD_MODE_EN
                    sub_d   = sub;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_n;
                if (cnt_q == CntLast) begin
                    // Counter parks at WIDTH-1 rather than wrapping.
                    borrow_d = br_n;
                    ovf_d    = ovf_n;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
`ifdef BIT_SERIAL_ADD_MODE_EN
            sub_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
`ifdef BIT_SERIAL_ADD_MODE_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q == StShift);
    assign out_valid  = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=8). A protocol-level model
// with plain integer arithmetic predicts handshake outputs every cycle and the
// result while DONE; directed vectors additionally pin literal results.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef BIT_SERIAL_ADD_MODE_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: unsigned wrap, unsigned borrow/carry, signed range check.
    function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic is_sub, output logic [W-1:0] r,
                                   output logic c, output logic v);
        longint unsigned ux, uy;
        longint sx, sy, sr, maxpos, minneg;
        ux = 64'(x);
        uy = 64'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        maxpos = (longint'(1) <<< (W - 1)) - 1;
        minneg = -(longint'(1) <<< (W - 1));
        if (is_sub) begin
            r  = W'(ux - uy);
            c  = (ux < uy);
            sr = sx - sy;
        end else begin
            r  = W'(ux + uy);
            c  = ((ux + uy) >> W) != 0;
            sr = sx + sy;
        end
        v = (sr > maxpos) || (sr < minneg);
    endfunction

    // Model: 0 = idle, 1 = computing, 2 = result presented.
    int           m_st  = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_diff, p_diff;
    logic         m_bo, m_ovf, p_bo, p_ovf;
    logic         m_sub_in;

`ifdef BIT_SERIAL_ADD_MODE_EN
    assign m_sub_in = sub;
`else
    assign m_sub_in = 1'b1;
`endif

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            m_st   = 0;
            m_diff = '0;
            m_bo   = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    ref_op(a, b, m_sub_in, p_diff, p_bo, p_ovf);
                    m_cnt = 0;
                    m_st  = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_diff = p_diff;
                        m_bo   = p_bo;
                        m_ovf  = p_ovf;
                        m_st   = 2;
                    end
                end
                default: if (out_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk_bit("in_ready", in_ready, m_st == 0);
            chk_bit("busy", busy, m_st == 1);
            chk_bit("out_valid", out_valid, m_st == 2);
            if (m_st == 2) begin
                chk_vec("model_diff", diff, m_diff);
                chk_bit("model_borrow", borrow_out, m_bo);
                chk_bit("model_ovf", ovf, m_ovf);
            end
        end
    end

    // Called one negedge after the accept edge; returns cycles until out_valid.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_timeout: got no out_valid expected one within %0d cycles",
                     W + 10);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic ev);
        int lat;
        @(negedge clk);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~x;
        b        = x;
        wait_result(lat);
        if (lat > 0) begin
            chk_int("latency", lat, W);
            chk_vec("lit_diff", diff, ed);
            chk_bit("lit_borrow", borrow_out, eb);
            chk_bit("lit_ovf", ovf, ev);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] bb_a [4];
    logic [W-1:0] bb_b [4];
    logic [W-1:0] bb_d [4];
    logic         bb_v [4];

    initial begin
        int lat;
        int idx_in, idx_out, last_acc;
        bit pending, seen_valid;

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b1;
        repeat (2) @(negedge clk);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_vec("rst_diff", diff, 8'h00);
        chk_bit("rst_borrow", borrow_out, 1'b0);
        chk_bit("rst_ovf", ovf, 1'b0);
        rstn   = 1'b1;
        chk_en = 1'b1;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Backpressure: result held 20 cycles while new operands are offered.
        @(negedge clk);
        a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        a = 8'h33; b = 8'h11; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk_vec("hold_diff", diff, 8'hF0);
            chk_bit("hold_borrow", borrow_out, 1'b1);
            chk_bit("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_bit("release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        chk_vec("after_hold_diff", diff, 8'h22);

        // Reset on SHIFT cycle 4 discards the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_vec("midrst_diff", diff, 8'h00);
        chk_bit("midrst_borrow", borrow_out, 1'b0);
        chk_bit("midrst_ovf", ovf, 1'b0);
        seen_valid = 1'b0;
        repeat (3 * W) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk_bit("midrst_no_result", seen_valid, 1'b0);
        run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

        // Back-to-back issue with out_ready held high.
        bb_a = '{8'h05, 8'h00, 8'hC8, 8'h64};
        bb_b = '{8'h03, 8'h01, 8'h64, 8'hC8};
        bb_d = '{8'h02, 8'hFF, 8'h64, 8'h9C};
        bb_v = '{1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        idx_in = 0; idx_out = 0; pending = 1'b0; last_acc = -1;
        a = bb_a[0]; b = bb_b[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100 && idx_out < 4; k++) begin
            if (pending) begin
                pending = 1'b0;
                idx_in++;
                if (idx_in < 4) begin
                    a = bb_a[idx_in];
                    b = bb_b[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_ready && in_valid) begin
                pending = 1'b1;
                if (last_acc >= 0) chk_int("issue_interval", cyc - last_acc, W + 2);
                last_acc = cyc;
            end
            if (out_valid) begin
                chk_vec("b2b_diff", diff, bb_d[idx_out]);
                chk_bit("b2b_ovf", ovf, bb_v[idx_out]);
                idx_out++;
            end
            @(negedge clk);
        end
        chk_int("b2b_results", idx_out, 4);

`ifdef BIT_SERIAL_ADD_MODE_EN
        sub = 1'b0;
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        sub = 1'b1;
        run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
